system_pio_in_irq: RTL and testbench
====================================

Name: system_pio_in_irq

Overview:
Parametrised Avalon-MM input PIO with interrupt, for pushbuttons and switches on the Nios II system bus. It is the multi-bit successor of the single-bit edge-capture input port. Per channel it adds:
- a two-flop synchroniser;
- a programmable debounce filter;
- independent rising/falling edge enables;
- write-1-to-clear capture bits.
A single level IRQ goes to the processor.

Parameters:
WIDTH, 8, number of input channels (1..32)
DB_W, 16, width of the debounce threshold register and per-channel counters
DB_DEFAULT, 16'd1000, threshold value loaded at reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high; sampled on rising clk
address  in  3  word address
chipselect  in  1  Avalon slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
in_port  in  WIDTH  asynchronous external inputs
readdata  out  32  registered read data
irq  out  1  level interrupt to CPU

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high. All state changes on the rising edge of clk only.
- Reset values:
  - readdata=0, sync1=sync2=0, stable=0, counters=0
  - rise_en=all 1s, fall_en=0, irq_mask=0, edge_capture=0
  - threshold=DB_DEFAULT; irq=0
- Register map (read/write below are Avalon accesses; write = chipselect & ~write_n):
  - 0 data: stable[WIDTH-1:0], read-only; writes ignored.
  - 1 rise_en: R/W, bits [WIDTH-1:0].
  - 2 irq_mask: R/W.
  - 3 edge_capture: read returns capture bits; write clears each bit where writedata=1; bits where writedata=0 are untouched.
  - 4 fall_en: R/W.
  - 5 threshold: R/W, bits [DB_W-1:0].
  - 6, 7: read 0; writes ignored.
- Unused upper readdata bits always 0. Writedata bits above WIDTH (or DB_W) are dropped.
- Read latency 1: readdata is registered every cycle from address, independent of chipselect, matching the existing PIO. No wait states.
- Synchroniser: sync1<=in_port; sync2<=sync1.
- Debounce, per channel i:
  - If sync2[i]==stable[i]: cnt[i]<=0.
  - Else if threshold<=1 or cnt[i]==threshold-1: stable[i]<=sync2[i], cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1.
  - So stable flips on the T-th consecutive edge with a mismatch, where T=max(threshold,1). A glitch shorter than T cycles resets the counter and never reaches stable.
- Latency, for a clean in_port step sampled at edge 0:
  - sync2 at edge 1;
  - stable at edge 1+T;
  - edge_capture at edge 2+T.
- Edge detect: a registered prev copy of stable.
  - rise = stable & ~prev & rise_en
  - fall = ~stable & prev & fall_en
  - ev = rise | fall
- edge_capture[i]:
  - set to 1 when ev[i];
  - otherwise cleared when a write to address 3 has writedata[i]=1;
  - otherwise held.
  - If ev and a clear hit the same bit in the same cycle, set wins, so no event is lost.
- Threshold change mid-count: the new value applies next cycle. A counter already >= new threshold-1 fires on the next mismatch cycle; use the compare cnt>=threshold-1 to guarantee this.
- Mask/enable changes do not alter edge_capture. Disabling rise_en/fall_en stops only new sets.
- irq = |(edge_capture & irq_mask). It is combinational from registers, so it has no glitches from in_port.
- Reset asserted mid-debounce or mid-capture returns all state to reset values on that edge. Pending edges are lost. The threshold returns to DB_DEFAULT.

Test Plan:
1. Reset, then read addresses 0..7 -> readdata one cycle later: 0, all 1s (WIDTH bits), 0, 0, 0, DB_DEFAULT, 0, 0. irq=0.
2. threshold=4; in_port[0] 0->1 held; irq_mask=1 -> stable[0] at edge 5 after sampling, edge_capture[0]=1 at edge 6, irq=1. Write 3 with 0x1 -> capture[0]=0, irq=0.
3. threshold=4; a 3-cycle pulse on in_port[2] -> data and edge_capture never change.
4. threshold=1, fall_en=0x2, rise_en=0; in_port[1] 1->0 -> capture=0x2. Bit 1 rising -> no capture.
5. capture=0x5; write 3 with 0x1 in the same cycle a new edge on bit 0 lands -> capture=0x5 (set wins). Write 3 with 0x4 -> capture=0x1.
6. Assert reset while cnt[0]=2 and capture=0xFF -> next cycle all counters, capture and irq are 0, and threshold=DB_DEFAULT.

Source files
------------

// File: rtl/system_pio_in_irq.sv
// Avalon-MM input PIO: per-channel two-flop synchroniser, debounce filter,
// rise/fall edge capture with write-1-to-clear, and a level IRQ to the CPU.
module system_pio_in_irq #(
  parameter int              WIDTH      = 8,
  parameter int              DB_W       = 16,
  parameter logic [DB_W-1:0] DB_DEFAULT = DB_W'(1000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_RISE_EN = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN = 3'd4;
  localparam logic [2:0] ADDR_THRESH  = 3'd5;

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] stable_reg;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] rise_en_reg;
  logic [WIDTH-1:0] fall_en_reg;
  logic [WIDTH-1:0] irq_mask_reg;
  logic [WIDTH-1:0] edge_capture_reg;
  logic [DB_W-1:0]  threshold_reg;
  logic [DB_W-1:0]  cnt_reg [WIDTH];
  logic [31:0]      readdata_reg;

  logic [WIDTH-1:0] stable_next;
  logic [WIDTH-1:0] edge_capture_next;
  logic [DB_W-1:0]  cnt_next [WIDTH];
  logic [31:0]      readdata_next;

  logic             wr_en;
  logic             thr_le1;
  logic [DB_W-1:0]  thr_m1;
  logic [WIDTH-1:0] wdata_w;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] ev;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata_w      = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign thr_le1      = (threshold_reg <= DB_W'(1));
  assign thr_m1       = threshold_reg - DB_W'(1);
  assign clr_mask     = (wr_en && (address == ADDR_CAPTURE)) ? wdata_w : '0;

  assign rise = stable_reg & ~prev_reg & rise_en_reg;
  assign fall = ~stable_reg & prev_reg & fall_en_reg;
  assign ev   = rise | fall;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic mismatch;
      logic fire;

      assign mismatch = sync2_reg[gi] ^ stable_reg[gi];
      // Greater-or-equal so a lowered threshold fires on the next mismatch.
      assign fire     = thr_le1 | (cnt_reg[gi] >= thr_m1);

      assign stable_next[gi] = (mismatch & fire) ? sync2_reg[gi] : stable_reg[gi];
      assign cnt_next[gi]    = (!mismatch || fire) ? '0 : cnt_reg[gi] + DB_W'(1);

      // A new event beats a simultaneous clear so no edge is lost.
      assign edge_capture_next[gi] = ev[gi] | (edge_capture_reg[gi] & ~clr_mask[gi]);
    end
  endgenerate

  always_comb begin
    readdata_next = '0;
    case (address)
      ADDR_DATA:    readdata_next = 32'(stable_reg);
      ADDR_RISE_EN: readdata_next = 32'(rise_en_reg);
      ADDR_MASK:    readdata_next = 32'(irq_mask_reg);
      ADDR_CAPTURE: readdata_next = 32'(edge_capture_reg);
      ADDR_FALL_EN: readdata_next = 32'(fall_en_reg);
      ADDR_THRESH:  readdata_next = 32'(threshold_reg);
      default:      readdata_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg        <= '0;
      sync2_reg        <= '0;
      stable_reg       <= '0;
      prev_reg         <= '0;
      rise_en_reg      <= '1;
      fall_en_reg      <= '0;
      irq_mask_reg     <= '0;
      edge_capture_reg <= '0;
      threshold_reg    <= DB_DEFAULT;
      readdata_reg     <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_reg[i] <= '0;
      end
    end else begin
      sync1_reg        <= in_port;
      sync2_reg        <= sync1_reg;
      stable_reg       <= stable_next;
      prev_reg         <= stable_reg;
      edge_capture_reg <= edge_capture_next;
      readdata_reg     <= readdata_next;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_reg[i] <= cnt_next[i];
      end
      if (wr_en) begin
        case (address)
          ADDR_RISE_EN: rise_en_reg   <= wdata_w;
          ADDR_MASK:    irq_mask_reg  <= wdata_w;
          ADDR_FALL_EN: fall_en_reg   <= wdata_w;
          ADDR_THRESH:  threshold_reg <= writedata[DB_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign readdata = readdata_reg;
  assign irq      = |(edge_capture_reg & irq_mask_reg);

endmodule

// File: tb/tb_system_pio_in_irq.sv
// Bench for system_pio_in_irq: register table, hand-timed corner sequences,
// then randomized traffic against a cycle-level reference model.
module tb_system_pio_in_irq;

  localparam int WIDTH = 8;
  localparam int DB_W  = 16;

  logic             clk        = 1'b0;
  logic             reset      = 1'b1;
  logic [2:0]       address    = '0;
  logic             chipselect = 1'b0;
  logic             write_n    = 1'b1;
  logic [31:0]      writedata  = '0;
  logic [WIDTH-1:0] in_port    = '0;
  logic [31:0]      readdata;
  logic             irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  system_pio_in_irq #(.WIDTH(WIDTH), .DB_W(DB_W), .DB_DEFAULT(16'd1000)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  // Reference model: debounce expressed as consecutive-mismatch run lengths.
  logic [WIDTH-1:0] m_s1, m_s2, m_stab, m_prev, m_rise, m_fall, m_mask, m_cap;
  int               m_run [WIDTH];
  int               m_thr;
  logic [31:0]      m_rd;
  bit               m_wr;
  int               m_t;

  task model_step();
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_prev = '0;
      m_rise = '1; m_fall = '0; m_mask = '0; m_cap = '0;
      m_thr = 1000; m_rd = '0;
      for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
    end else begin
      m_wr = chipselect && !write_n;
      case (address)
        3'd0: m_rd = 32'(m_stab);
        3'd1: m_rd = 32'(m_rise);
        3'd2: m_rd = 32'(m_mask);
        3'd3: m_rd = 32'(m_cap);
        3'd4: m_rd = 32'(m_fall);
        3'd5: m_rd = 32'(m_thr);
        default: m_rd = 32'd0;
      endcase
      for (int i = 0; i < WIDTH; i++) begin
        if ((m_stab[i] != m_prev[i]) && (m_stab[i] ? m_rise[i] : m_fall[i]))
          m_cap[i] = 1'b1;
        else if (m_wr && address == 3'd3 && writedata[i])
          m_cap[i] = 1'b0;
      end
      m_prev = m_stab;
      m_t = (m_thr < 1) ? 1 : m_thr;
      for (int i = 0; i < WIDTH; i++) begin
        if (m_s2[i] == m_stab[i]) m_run[i] = 0;
        else begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= m_t) begin
            m_stab[i] = m_s2[i];
            m_run[i] = 0;
          end
        end
      end
      if (m_wr) begin
        case (address)
          3'd1: m_rise = writedata[WIDTH-1:0];
          3'd2: m_mask = writedata[WIDTH-1:0];
          3'd4: m_fall = writedata[WIDTH-1:0];
          3'd5: m_thr  = int'(writedata[15:0]);
          default: ;
        endcase
      end
      m_s2 = m_s1;
      m_s1 = in_port;
    end
  endtask

  task tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task wait_cycles(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task do_reset();
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    $display("write addr=%0d data=0x%08h", a, d);
  endtask

  task bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    chipselect = 1'b0;
    d = readdata;
    $display("read  addr=%0d data=0x%08h", a, d);
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [16];
  logic [31:0] rd;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{3'd0, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{3'd1, 1'b0, 32'h0,        32'hFF};
    vecs[2]  = '{3'd2, 1'b0, 32'h0,        32'h0};
    vecs[3]  = '{3'd3, 1'b0, 32'h0,        32'h0};
    vecs[4]  = '{3'd4, 1'b0, 32'h0,        32'h0};
    vecs[5]  = '{3'd5, 1'b0, 32'h0,        32'd1000};
    vecs[6]  = '{3'd6, 1'b0, 32'h0,        32'h0};
    vecs[7]  = '{3'd7, 1'b0, 32'h0,        32'h0};
    vecs[8]  = '{3'd1, 1'b1, 32'hFFFFFF5A, 32'h5A};
    vecs[9]  = '{3'd2, 1'b1, 32'h0000013C, 32'h3C};
    vecs[10] = '{3'd4, 1'b1, 32'hA5A5A5A5, 32'hA5};
    vecs[11] = '{3'd5, 1'b1, 32'hABCD1234, 32'h1234};
    vecs[12] = '{3'd0, 1'b1, 32'h000000FF, 32'h0};
    vecs[13] = '{3'd6, 1'b1, 32'h000000FF, 32'h0};
    vecs[14] = '{3'd7, 1'b1, 32'h000000FF, 32'h0};
    vecs[15] = '{3'd3, 1'b1, 32'h000000FF, 32'h0};

    // Reset state and register map
    do_reset();
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    for (int v = 0; v < 16; v++) begin
      if (vecs[v].wr) bus_write(vecs[v].addr, vecs[v].wdata);
      bus_read(vecs[v].addr, rd);
      check($sformatf("vec%0d_addr%0d", v, vecs[v].addr), rd, vecs[v].exp);
    end

    // Clean rising step with threshold 4: stable at edge 5, capture at edge 6
    do_reset();
    bus_write(3'd5, 32'd4);
    bus_write(3'd2, 32'h1);
    address = 3'd0;
    in_port = 8'h01;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e == 5) begin
        check("step_data_e5", readdata, 32'h0);
        check("step_irq_e5", 32'(irq), 32'h0);
      end
      if (e == 6) begin
        check("step_data_e6", readdata, 32'h1);
        check("step_irq_e6", 32'(irq), 32'h1);
      end
    end
    bus_write(3'd3, 32'h1);
    check("clear_irq", 32'(irq), 32'h0);
    bus_read(3'd3, rd);
    check("clear_capture", rd, 32'h0);

    // Three-cycle glitch on bit 2 must be filtered out
    address = 3'd0;
    in_port = 8'h05;
    wait_cycles(3);
    in_port = 8'h01;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("glitch_data", readdata, 32'h1);
    end
    bus_read(3'd3, rd);
    check("glitch_capture", rd, 32'h0);

    // Threshold 1, fall-only enable on bit 1
    bus_write(3'd1, 32'h0);
    bus_write(3'd4, 32'h2);
    bus_write(3'd5, 32'h1);
    in_port = 8'h03;
    wait_cycles(6);
    bus_read(3'd0, rd);
    check("fall_data_hi", rd, 32'h3);
    bus_read(3'd3, rd);
    check("rise_disabled", rd, 32'h0);
    in_port = 8'h01;
    wait_cycles(6);
    bus_read(3'd3, rd);
    check("fall_capture", rd, 32'h2);
    bus_write(3'd3, 32'hFF);

    // Set wins over a same-cycle clear
    bus_write(3'd4, 32'h0);
    bus_write(3'd1, 32'h5);
    in_port = 8'h00;
    wait_cycles(6);
    in_port = 8'h05;
    wait_cycles(6);
    bus_read(3'd3, rd);
    check("cap_0x5", rd, 32'h5);
    in_port = 8'h00;
    wait_cycles(6);
    bus_read(3'd3, rd);
    check("no_fall_cap", rd, 32'h5);
    in_port = 8'h01;
    wait_cycles(3);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, rd);
    check("set_wins", rd, 32'h5);
    bus_write(3'd3, 32'h4);
    bus_read(3'd3, rd);
    check("partial_clear", rd, 32'h1);

    // Reset in the middle of a debounce count with everything captured
    in_port = 8'h00;
    wait_cycles(6);
    bus_write(3'd1, 32'hFF);
    in_port = 8'hFF;
    wait_cycles(6);
    bus_read(3'd3, rd);
    check("cap_0xff", rd, 32'hFF);
    bus_write(3'd2, 32'hFF);
    check("irq_all", 32'(irq), 32'h1);
    bus_write(3'd5, 32'd5);
    in_port = 8'hFE;
    wait_cycles(4);
    reset = 1'b1;
    tick();
    check("midreset_irq", 32'(irq), 32'h0);
    check("midreset_readdata", readdata, 32'h0);
    reset = 1'b0;
    bus_read(3'd5, rd);
    check("midreset_thresh", rd, 32'd1000);
    bus_read(3'd3, rd);
    check("midreset_capture", rd, 32'h0);
    bus_read(3'd0, rd);
    check("midreset_data", rd, 32'h0);
    bus_read(3'd2, rd);
    check("midreset_mask", rd, 32'h0);

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0)
        in_port = in_port ^ WIDTH'($urandom & $urandom & $urandom);
      address    = 3'($urandom_range(0, 7));
      chipselect = ($urandom_range(0, 3) == 0);
      write_n    = 1'($urandom_range(0, 1));
      writedata  = (address == 3'd5) ? 32'($urandom_range(0, 4)) : $urandom;
      if (chipselect && !write_n && !reset)
        $display("rnd %0d write addr=%0d data=0x%08h", n, address, writedata);
      tick();
      check("rnd_readdata", readdata, m_rd);
      check("rnd_irq", 32'(irq), 32'(|(m_cap & m_mask)));
    end
    reset = 1'b0;
    chipselect = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
